biquad8_coeff_loader: RTL
=========================

# biquad8_coeff_loader

Upstream sequencer for the incremental IIR stage of the biquad8 filter. It takes a feedback coefficient pair (coeff0, coeff1) from the control side and serialises it into the stage's B-register shift chain, one 18-bit word per clock. It then issues a single commit pulse so that every DSP in the chain switches to the new pair on the same clock. It owns the stage's `coeff_dat`, `coeff_wr` and `coeff_update` inputs exclusively.

## Interface
Parameters:
- NSAMP, 8: samples per clock of the filter. The chain length is NW = 2*(NSAMP-2) words. Legal values are 3 to 16.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- coeff0_i  in  18  signed coefficient for y[i-1]. Captured on an accepted load.
- coeff1_i  in  18  signed coefficient for y[i-2]. Captured on an accepted load.
- load_i  in  1  load request. Sampled every clock; accepted only in IDLE.
- busy_o  out  1  high from the cycle after acceptance through the commit cycle.
- done_o  out  1  one-cycle pulse on return to IDLE after a commit.
- coeff_dat_o  out  18  serial coefficient word, to the stage's `coeff_dat_i`.
- coeff_wr_o  out  1  shift enable, to the stage's `coeff_wr_i`.
- coeff_update_o  out  1  commit pulse, to the stage's `coeff_update_i`.
- active0_o  out  18  coeff0 currently committed in the DSPs.
- active1_o  out  18  coeff1 currently committed in the DSPs.

## Operation
- Downstream contract: the stage registers both `coeff_wr` and `coeff_update` once before use, but uses `coeff_dat` unregistered.
  - Therefore the data word for write k must appear one cycle after `coeff_wr_o` is high for write k.
- Chain order: the word written first ends up in the farthest DSP. Chain positions p = 0..NW-1 run sample2-low, sample2-high, sample3-low, …; even p holds coeff0 and odd p holds coeff1.
  - Write k lands in position NW-1-k.
  - Even k carries coeff1; odd k carries coeff0.
- States:
  - IDLE: load_i=1 captures coeff0_i and coeff1_i into holding registers, clears the write counter, and moves to SHIFT.
  - SHIFT: `coeff_wr_o` is high for NW consecutive cycles; the counter runs 0..NW-1; then move to COMMIT.
  - COMMIT: one cycle. The last data word is on `coeff_dat_o` and `coeff_update_o`=1. Copy the holding registers into active0_o and active1_o. Move to IDLE.
  - On entering IDLE from COMMIT, done_o=1 for that cycle.
- `coeff_dat_o` is 0 whenever it is not in a data cycle. Data cycles are the NW cycles following each `coeff_wr_o` cycle.
- load_i while busy: ignored, and nothing is queued. The holding registers must not change during SHIFT or COMMIT.
- load_i in the same cycle as done_o: accepted, because the state is IDLE.
- Reset, at any time including mid-SHIFT: state goes to IDLE and the counter is cleared.
  - No `coeff_update_o` is issued, so the DSPs keep their previously committed B2 values. The partially shifted B1 chain is harmless because the next load rewrites all NW words.
  - active0_o and active1_o reset to 0, matching the DSP B2 power-on state.
- All outputs are registered.

## Timing
Load accepted at cycle 0 (the edge where IDLE sees load_i=1):

| Signal | Cycles (N = NW) |
|---|---|
| `coeff_wr_o` | 1 .. N |
| `coeff_dat_o` (word k in cycle k+2) | 2 .. N+1 |
| `coeff_update_o` | N+1 |
| busy_o | 1 .. N+1 |
| done_o | N+2 |
| active0_o, active1_o (new values) | from N+2 |
| next load accepted | N+2 at the earliest |

- Stage view: its B1 shifts at cycles 2..N+1 and its B2 loads at N+2, so the new coefficients take effect on the DSP multiply from cycle N+3.
- Reset values: busy_o, done_o, `coeff_wr_o` and `coeff_update_o` = 0; `coeff_dat_o` = 0; active0_o and active1_o = 0.
- Pin-to-pin: the loader adds no combinational path from any input to any output.

## Test plan
1. **Basic load, NSAMP=8 (NW=12).** Apply coeff0=0x0ABCD, coeff1=0x3F00F and load at cycle 0.
   - `coeff_wr_o` is high in cycles 1–12.
   - `coeff_dat_o` alternates 0x3F00F, 0x0ABCD, … over cycles 2–13.
   - `coeff_update_o` is high in cycle 13 only; done_o is high in cycle 14; active outputs equal the new pair from cycle 14.
   - A behavioural model of the 12-DSP B1/B2 chain holds coeff0 in even positions and coeff1 in odd positions.
2. **NSAMP=4 (NW=4).** Load at cycle 0.
   - `coeff_wr_o` is high in cycles 1–4; data in cycles 2–5; update in cycle 5; done in cycle 6.
3. **Load while busy.** A second load with different values at cycle 5 of test 1.
   - The output stream and active outputs are identical to test 1, and no second sequence starts.
4. **Back-to-back.** Load B asserted in the done_o cycle of load A.
   - B's `coeff_wr_o` starts the next cycle, and the chain model ends holding B's values.
5. **Reset mid-SHIFT.** Commit pair A, start loading pair B, and assert rst at cycle 6 for one cycle.
   - No update pulse appears for B; the chain model's B2 still holds A. active outputs read 0 after reset.
   - A following load of C commits C correctly.
6. **Sign extremes.** Use coeff0=0x20000 and coeff1=0x1FFFF.
   - The bits are passed through unmodified.

Source files
------------

// File: rtl/biquad8_coeff_loader.sv
// Serialises a feedback coefficient pair into the biquad8 IIR stage's B1 shift
// chain, one word per clock, then issues a single commit pulse so every DSP switches at once.
module biquad8_coeff_loader #(
  parameter int NSAMP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] coeff0_i,
  input  logic [17:0] coeff1_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [17:0] coeff_dat_o,
  output logic        coeff_wr_o,
  output logic        coeff_update_o,
  output logic [17:0] active0_o,
  output logic [17:0] active1_o
);

  localparam int NW = 2 * (NSAMP - 2);
  localparam int CW = (NW > 2) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [17:0] hold0_q, hold0_d;
  logic [17:0] hold1_q, hold1_d;
  logic [17:0] act0_q, act0_d;
  logic [17:0] act1_q, act1_d;
  logic [17:0] dat_q, dat_d;
  logic        wr_q, wr_d;
  logic        upd_q, upd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold0_q <= '0;
      hold1_q <= '0;
      act0_q  <= '0;
      act1_q  <= '0;
      dat_q   <= '0;
      wr_q    <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      act0_q  <= act0_d;
      act1_q  <= act1_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The stage registers wr/update but uses data directly, so each data word
  // is launched one cycle after its write strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    act0_d  = act0_q;
    act1_d  = act1_q;
    dat_d   = '0;
    wr_d    = 1'b0;
    upd_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          hold0_d = coeff0_i;
          hold1_d = coeff1_i;
          cnt_d   = '0;
          state_d = S_SHIFT;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        // Even writes land in odd chain positions, which hold coeff1.
        dat_d  = cnt_q[0] ? hold0_q : hold1_q;
        if (cnt_q == LAST) begin
          state_d = S_COMMIT;
          upd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          wr_d  = 1'b1;
        end
      end
      S_COMMIT: begin
        act0_d  = hold0_q;
        act1_d  = hold1_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign coeff_dat_o    = dat_q;
  assign coeff_wr_o     = wr_q;
  assign coeff_update_o = upd_q;
  assign active0_o      = act0_q;
  assign active1_o      = act1_q;

endmodule
